// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: front-end controller for the word-addressed instruction RAM.
// Arbitrates the core fetch port (read-only) and the loader/debug port
// (read/write) onto one synchronous single-port RAM. One grant per cycle,
// round-robin on ties, address range/alignment checking, and a response
// exactly one cycle after the accept.
//
// Optional feature macro: IMEM_BOOT_LOCK_EN
//   Defined     -> fetch is held off (f_req_ready = 0) after reset until
//                  boot_done is sampled high; the loader owns the RAM until then.
//   Not defined -> boot_done is ignored; fetch arbitrates from the first cycle.

module inst_mem_ctrl #(
    parameter int          DEPTH    = 1024,
    parameter int          IDX_W    = 10,
    parameter logic [31:0] ERR_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,

    // Fetch port (read-only)
    input  logic             f_req_valid,
    output logic             f_req_ready,
    input  logic [31:0]      f_addr,
    output logic             f_rsp_valid,
    output logic [31:0]      f_rsp_inst,
    output logic             f_rsp_err,

    // Loader / debug port (read/write)
    input  logic             l_req_valid,
    output logic             l_req_ready,
    input  logic             l_we,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_rsp_valid,
    output logic [31:0]      l_rsp_rdata,
    output logic             l_rsp_err,

    // RAM side
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,

    input  logic             boot_done
);

    // Word-index limit at the width of addr[31:2], so the range compare is
    // a plain 30-bit unsigned compare.
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    // An address is rejected when it is not word aligned or when its word
    // index lies beyond the end of the RAM.
    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH_W);
    endfunction

    // ------------------------------------------------------------------
    // State: last grant owner, boot lock, and the response registers.
    // ------------------------------------------------------------------
    logic r_last_ld;      // 1 = loader held the most recent grant
    logic r_f_rsp_valid;
    logic r_f_rsp_err;
    logic r_l_rsp_valid;
    logic r_l_rsp_err;
    logic r_l_rsp_wr;     // loader response belongs to a write (data = 0)

    logic w_unlocked;
    logic w_f_elig;
    logic w_f_grant;
    logic w_l_grant;
    logic w_f_bad;
    logic w_l_bad;

`ifdef IMEM_BOOT_LOCK_EN
    logic r_unlocked;

    // Boot lock: sticky once boot_done is seen, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unlocked <= 1'b0;
        end else if (boot_done) begin
            r_unlocked <= 1'b1;
        end
    end

    assign w_unlocked = r_unlocked;
`else
    // boot_done has no role without the lock; tie it off explicitly.
    logic w_unused_boot_done;
    assign w_unused_boot_done = boot_done;
    assign w_unlocked         = 1'b1;
`endif

    assign w_f_bad  = addr_bad(f_addr);
    assign w_l_bad  = addr_bad(l_addr);
    assign w_f_elig = f_req_valid && w_unlocked;

    // Grant: a lone requester wins; on a tie the side that did not win
    // last time gets the RAM (fetch first after reset).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path can leave it unassigned and infer a latch.
        w_f_grant = 1'b0;
        w_l_grant = 1'b0;
        if (w_f_elig && l_req_valid) begin
            w_f_grant = r_last_ld;
            w_l_grant = !r_last_ld;
        end else if (w_f_elig) begin
            w_f_grant = 1'b1;
        end else if (l_req_valid) begin
            w_l_grant = 1'b1;
        end
    end

    // Nothing is queued internally: ready is simply the grant.
    assign f_req_ready = w_f_grant;
    assign l_req_ready = w_l_grant;

    // RAM drive for the granted request; an errored request never enables
    // the RAM, so a bad write is dropped on the floor.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        if (w_f_grant) begin
            mem_en  = !w_f_bad;
            mem_idx = f_addr[IDX_W+1:2];
        end else if (w_l_grant) begin
            mem_en    = !w_l_bad;
            mem_we    = !w_l_bad && l_we;
            mem_idx   = l_addr[IDX_W+1:2];
            mem_wdata = l_we ? l_wdata : 32'h0;
        end
    end

    // Round-robin history: any accepted request, good or errored, counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_ld <= 1'b1;
        end else if (w_f_grant) begin
            // NOTE: clocked state is always updated with non-blocking
            // assignments so every register samples pre-edge values.
            r_last_ld <= 1'b0;
        end else if (w_l_grant) begin
            r_last_ld <= 1'b1;
        end
    end

    // Response qualifiers, one cycle after accept. Reset wipes any response
    // that was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_rsp_valid <= 1'b0;
            r_f_rsp_err   <= 1'b0;
            r_l_rsp_valid <= 1'b0;
            r_l_rsp_err   <= 1'b0;
            r_l_rsp_wr    <= 1'b0;
        end else begin
            r_f_rsp_valid <= w_f_grant;
            r_f_rsp_err   <= w_f_grant && w_f_bad;
            r_l_rsp_valid <= w_l_grant;
            r_l_rsp_err   <= w_l_grant && w_l_bad;
            r_l_rsp_wr    <= w_l_grant && l_we;
        end
    end

    // The RAM output register is the data register of the response; here it
    // is only steered: ERR_INST / 0 on error, 0 for writes, 0 when idle.
    assign f_rsp_valid = r_f_rsp_valid;
    assign f_rsp_err   = r_f_rsp_err;
    assign f_rsp_inst  = !r_f_rsp_valid ? 32'h0    :
                         r_f_rsp_err    ? ERR_INST : mem_rdata;

    assign l_rsp_valid = r_l_rsp_valid;
    assign l_rsp_err   = r_l_rsp_err;
    assign l_rsp_rdata = (r_l_rsp_valid && !r_l_rsp_err && !r_l_rsp_wr) ?
                         mem_rdata : 32'h0;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb_inst_mem_ctrl: directed bench for inst_mem_ctrl with a behavioural
// write-first RAM, a shadow image for expected data, and a queue-based
// scoreboard drained by a monitor whenever a response is presented.

module tb_inst_mem_ctrl;

    localparam int          DEPTH    = 1024;
    localparam int          IDX_W    = 10;
    localparam logic [31:0] ERR_INST = 32'h0000_0013;

`ifdef IMEM_BOOT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             f_req_valid;
    logic             f_req_ready;
    logic [31:0]      f_addr;
    logic             f_rsp_valid;
    logic [31:0]      f_rsp_inst;
    logic             f_rsp_err;
    logic             l_req_valid;
    logic             l_req_ready;
    logic             l_we;
    logic [31:0]      l_addr;
    logic [31:0]      l_wdata;
    logic             l_rsp_valid;
    logic [31:0]      l_rsp_rdata;
    logic             l_rsp_err;
    logic             mem_en;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             boot_done;

    inst_mem_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ERR_INST(ERR_INST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_req_valid (f_req_valid),
        .f_req_ready (f_req_ready),
        .f_addr      (f_addr),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_inst  (f_rsp_inst),
        .f_rsp_err   (f_rsp_err),
        .l_req_valid (l_req_valid),
        .l_req_ready (l_req_ready),
        .l_we        (l_we),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_rsp_valid (l_rsp_valid),
        .l_rsp_rdata (l_rsp_rdata),
        .l_rsp_err   (l_rsp_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_idx     (mem_idx),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .boot_done   (boot_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port, write-first RAM.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_idx] <= mem_wdata;
                mem_rdata    <= mem_wdata;
            end else begin
                mem_rdata    <= ram[mem_idx];
            end
        end
    end

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        fq[$];
    rsp_t        lq[$];
    logic [31:0] shadow [DEPTH];
    int          n_vec = 0;
    int          n_err = 0;
    logic        last_ld_m;
    logic        unlocked_m;
    logic        obs_f;
    logic        obs_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    // One cycle of stimulus, entered 1 time unit after a rising edge and left
    // 1 time unit after the next one. Expected responses are queued here.
    task automatic step(input logic fv, input logic [31:0] fa,
                        input logic lv, input logic lwe,
                        input logic [31:0] la, input logic [31:0] lwd);
        logic        gf, gl, fe, le, en_e, we_e;
        logic [IDX_W-1:0] fi, li;
        rsp_t        r;
        f_req_valid = fv;
        f_addr      = fa;
        l_req_valid = lv;
        l_we        = lwe;
        l_addr      = la;
        l_wdata     = lwd;
        @(negedge clk);
        gf = fv && unlocked_m && (!lv || last_ld_m);
        gl = lv && !gf;
        fe = bad(fa);
        le = bad(la);
        fi = fa[IDX_W+1:2];
        li = la[IDX_W+1:2];
        obs_f = f_req_ready;
        obs_l = l_req_ready;
        check("ready", {30'd0, f_req_ready, l_req_ready}, {30'd0, gf, gl});
        en_e = (gf && !fe) || (gl && !le);
        we_e = gl && lwe && !le;
        check("mem_en_we", {30'd0, mem_en, mem_we}, {30'd0, en_e, we_e});
        if (en_e) check("mem_idx", 32'(mem_idx), gf ? 32'(fi) : 32'(li));
        if (we_e) check("mem_wdata", mem_wdata, lwd);
        if (gf) begin
            r.err  = fe;
            r.data = fe ? ERR_INST : shadow[fi];
            fq.push_back(r);
            last_ld_m = 1'b0;
        end
        if (gl) begin
            r.err  = le;
            r.data = (le || lwe) ? 32'h0 : shadow[li];
            lq.push_back(r);
            if (we_e) shadow[li] = lwd;
            last_ld_m = 1'b1;
        end
        @(posedge clk);
        if (LOCK && boot_done) unlocked_m = 1'b1;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Reset is applied asynchronously right where the caller stands.
    task automatic do_reset();
        rst_n       = 1'b0;
        f_req_valid = 1'b0;
        l_req_valid = 1'b0;
        fq.delete();
        lq.delete();
        last_ld_m   = 1'b1;
        unlocked_m  = !LOCK;
        #1;
        check("rsp_in_reset", {30'd0, f_rsp_valid, l_rsp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        check("outs_in_reset",
              {25'd0, f_rsp_valid, f_rsp_err, l_rsp_valid, l_rsp_err,
               mem_en, mem_we, f_req_ready},
              32'h0);
        check("data_in_reset", f_rsp_inst | l_rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (f_rsp_valid) begin
            if (fq.size() == 0) begin
                check("f_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = fq.pop_front();
                check("f_rsp_inst", f_rsp_inst, e.data);
                check("f_rsp_err", 32'(f_rsp_err), 32'(e.err));
            end
        end
        if (l_rsp_valid) begin
            if (lq.size() == 0) begin
                check("l_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = lq.pop_front();
                check("l_rsp_rdata", l_rsp_rdata, e.data);
                check("l_rsp_err", 32'(l_rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] image [4];
    logic [5:0]  pat;
    logic        any_f;
    int          k;
    int          fcnt;
    int          lcnt;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = 32'h0;
            shadow[i] = 32'h0;
        end
        image[0] = 32'h0050_0093;
        image[1] = 32'h0010_0113;
        image[2] = 32'h0020_8233;
        image[3] = 32'h0000_006F;
        rst_n     = 1'b0;
        boot_done = 1'b0;
        f_addr = 32'h0; l_addr = 32'h0; l_wdata = 32'h0; l_we = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Boot window: fetch asks continuously, loader downloads the image.
        any_f = 1'b0;
        k     = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h20, k < 4, 1'b1, 32'(k * 4), image[k % 4]);
            if (obs_f) any_f = 1'b1;
            if (obs_l) k++;
        end
        check("boot_window_fetch_grant", 32'(any_f), LOCK ? 32'd0 : 32'd1);
        check("image_loaded", 32'(k), 32'd4);
        boot_done = 1'b1;
        step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
        boot_done = 1'b0;
        step(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
        check("fetch_after_boot", 32'(obs_f), 32'd1);

        // Write then immediate fetch of the same word.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);

        // Tie-break: leave last_grant on the loader, then contend 6 cycles.
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h10, 1'b1, 1'b0, 32'h4, 32'h0);
            pat = {pat[4:0], obs_f};
        end
        check("rr_pattern", 32'(pat), 32'b101010);

        // Address errors.
        step(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'(DEPTH * 4), 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'(DEPTH * 4), 32'h1234_5678);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h2, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0);

        // Loader reads of the image interleaved with a fetch stream.
        fcnt = 0;
        lcnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'((fcnt % 4) * 4), lcnt < 4, 1'b0, 32'(lcnt * 4), 32'h0);
            if (obs_f) fcnt++;
            if (obs_l) lcnt++;
        end
        check("interleave_loader_done", 32'(lcnt), 32'd4);

        // Reset in the cycle after an accept: the response must vanish.
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        do_reset();
        idle();
        step(1'b1, 32'h10, 1'b1, 1'b0, 32'h10, 32'h0);
        idle();
        idle();

        check("f_queue_drained", 32'(fq.size()), 32'd0);
        check("l_queue_drained", 32'(lq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
